// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path.
// - rx_state_e   : frame FSM states.
// - SMP_OFS_*    : sample points relative to the middle of a bit period
//                  (three majority samples, then the resolve point).
// - PAR_EVEN/ODD : encodings of the PAR_TYP input.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      DONE
   } rx_state_e;

   localparam int SMP_OFS_EARLY   = -1;
   localparam int SMP_OFS_MID     = 0;
   localparam int SMP_OFS_LATE    = 1;
   localparam int SMP_OFS_RESOLVE = 2;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-period counter and 3-sample majority voter.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   en_i           : count while a frame is in progress; clears the counter otherwise
//   rx_i           : synchronized serial line
//   prescale_i     : oversampling ratio (cycles per bit)
//   bit_val_o      : majority of the three samples of the current bit
//   resolve_o      : one-cycle strobe when bit_val_o is valid for this bit
//   bit_end_o      : last cycle of the current bit period
module uart_rx_sampler
   import uart_rx_pkg::*;
#(
   parameter int PRESCALE_W = 6
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  en_i,
   input  logic                  rx_i,
   input  logic [PRESCALE_W-1:0] prescale_i,
   output logic                  bit_val_o,
   output logic                  resolve_o,
   output logic                  bit_end_o
);

   logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
   logic [2:0]            smp_q, smp_d;
   logic [PRESCALE_W-1:0] half, last;

   assign half = prescale_i >> 1;
   assign last = prescale_i - PRESCALE_W'(1);

   // ">=" rather than "==" so an out-of-range count (illegal or changed
   // Prescale) still wraps instead of running away.
   assign bit_end_o = (edge_cnt_q >= last);
   assign resolve_o = en_i && (edge_cnt_q == half + PRESCALE_W'(SMP_OFS_RESOLVE));
   assign bit_val_o = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

   always_comb begin
      edge_cnt_d = edge_cnt_q;
      smp_d      = smp_q;
      if (!en_i) begin
         edge_cnt_d = '0;
      end else begin
         edge_cnt_d = bit_end_o ? '0 : edge_cnt_q + PRESCALE_W'(1);
         if (edge_cnt_q == half + PRESCALE_W'(SMP_OFS_EARLY)) smp_d[0] = rx_i;
         if (edge_cnt_q == half + PRESCALE_W'(SMP_OFS_MID))   smp_d[1] = rx_i;
         if (edge_cnt_q == half + PRESCALE_W'(SMP_OFS_LATE))  smp_d[2] = rx_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         edge_cnt_q <= '0;
         smp_q      <= '1;
      end else begin
         edge_cnt_q <= edge_cnt_d;
         smp_q      <= smp_d;
      end
   end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: start detect, LSB-first data, optional parity, stop check.
// Ports:
//   CLK, RST    : oversampling clock, asynchronous active-low reset
//   RX_IN       : serial line (idle high, asynchronous to CLK)
//   PAR_EN      : parity bit follows the data bits
//   PAR_TYP     : 0 even, 1 odd parity
//   Prescale    : oversampling ratio (8, 16 or 32)
//   P_DATA      : last accepted byte
//   data_valid  : one-cycle pulse, frame accepted
//   par_err     : one-cycle pulse, parity mismatch
//   stp_err     : one-cycle pulse, stop bit sampled low
module uart_rx_frame
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic [PRESCALE_W-1:0] Prescale,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err
);

   localparam int BCW = $clog2(DATA_WIDTH + 1);

   rx_state_e             state_q, state_d;
   logic [1:0]            sync_q;
   logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
   logic                  par_bad_q, par_bad_d;
   logic                  dv_q, dv_d, pe_q, pe_d, se_q, se_d;
   logic                  rx_s, cnt_en, bit_val, resolve, bit_end;

   assign rx_s   = sync_q[1];
   assign cnt_en = (state_q != IDLE) && (state_q != DONE);

   uart_rx_sampler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_sampler (
      .clk_i      (CLK),
      .rst_ni     (RST),
      .en_i       (cnt_en),
      .rx_i       (rx_s),
      .prescale_i (Prescale),
      .bit_val_o  (bit_val),
      .resolve_o  (resolve),
      .bit_end_o  (bit_end)
   );

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_bad_d = par_bad_q;
      p_data_d  = p_data_q;
      dv_d      = 1'b0;
      pe_d      = 1'b0;
      se_d      = 1'b0;
      case (state_q)
         IDLE: begin
            bit_cnt_d = '0;
            par_bad_d = 1'b0;
            if (!rx_s) state_d = START;
         end
         START: begin
            if (resolve && bit_val) state_d = IDLE;   // glitch, not a start bit
            else if (bit_end)       state_d = DATA;
         end
         DATA: begin
            if (resolve) shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
            if (bit_end) begin
               bit_cnt_d = bit_cnt_q + BCW'(1);
               if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) state_d = PAR_EN ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (resolve) par_bad_d = bit_val != ((^shift_q) ^ (PAR_TYP == PAR_ODD));
            if (bit_end) state_d = STOP;
         end
         STOP: begin
            // Finish at the stop-bit resolve point so a start bit that follows
            // immediately is still seen. bit_end is a fallback for Prescale
            // values whose resolve point is never reached.
            if (resolve || bit_end) begin
               state_d = DONE;
               se_d    = !bit_val;
               pe_d    = par_bad_q;
               if (bit_val && !par_bad_q) begin
                  dv_d     = 1'b1;
                  p_data_d = shift_q;
               end
            end
         end
         DONE:    state_d = IDLE;   // result pulses are visible during this cycle
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= IDLE;
         sync_q    <= 2'b11;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_bad_q <= 1'b0;
         p_data_q  <= '0;
         dv_q      <= 1'b0;
         pe_q      <= 1'b0;
         se_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync_q    <= {sync_q[0], RX_IN};
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         par_bad_q <= par_bad_d;
         p_data_q  <= p_data_d;
         dv_q      <= dv_d;
         pe_q      <= pe_d;
         se_q      <= se_d;
      end
   end

   assign P_DATA     = p_data_q;
   assign data_valid = dv_q;
   assign par_err    = pe_q;
   assign stp_err    = se_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: a table of directed frames, hand
// sequences for glitch / back-to-back / mid-frame reset, then random frames
// checked against a parity/stop model.
module tb_uart_rx_frame;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       RX_IN = 1'b1;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic [5:0] Prescale = 6'd8;
   logic [7:0] P_DATA;
   logic       data_valid, par_err, stp_err;

   uart_rx_frame #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .RX_IN      (RX_IN),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .Prescale   (Prescale),
      .P_DATA     (P_DATA),
      .data_valid (data_valid),
      .par_err    (par_err),
      .stp_err    (stp_err)
   );

   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_fail = 0;
   int dv_cnt = 0, pe_cnt = 0, se_cnt = 0;
   logic [7:0] dv_log[$];
   logic [7:0] model_pd = 8'h00;

   // Count pulse cycles; a stuck output shows up as an inflated count.
   always @(negedge CLK) begin
      if (data_valid === 1'b1) begin
         dv_cnt++;
         dv_log.push_back(P_DATA);
      end
      if (par_err === 1'b1) pe_cnt++;
      if (stp_err === 1'b1) se_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                             input logic sbit, input int ps);
      RX_IN = 1'b0;
      tick(ps);
      for (int i = 0; i < 8; i++) begin
         RX_IN = d[i];
         tick(ps);
      end
      if (pen) begin
         RX_IN = pbit;
         tick(ps);
      end
      RX_IN = sbit;
      tick(ps);
      RX_IN = 1'b1;
   endtask

   task automatic run_frame(input string name, input int ps, input logic pen, input logic ptyp,
                            input logic [7:0] d, input logic pbit, input logic sbit,
                            input logic edv, input logic epe, input logic ese,
                            input logic [7:0] epd);
      int dv0, pe0, se0;
      Prescale = ps[5:0];
      PAR_EN   = pen;
      PAR_TYP  = ptyp;
      dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
      send_frame(d, pen, pbit, sbit, ps);
      tick(2 * ps);
      chk({name, ".data_valid"}, dv_cnt - dv0, {31'd0, edv});
      chk({name, ".par_err"},    pe_cnt - pe0, {31'd0, epe});
      chk({name, ".stp_err"},    se_cnt - se0, {31'd0, ese});
      chk({name, ".P_DATA"},     {24'd0, P_DATA}, {24'd0, epd});
   endtask

   typedef struct {
      int         ps;
      logic       pen;
      logic       ptyp;
      logic [7:0] data;
      logic       pbit;
      logic       sbit;
      logic       exp_dv;
      logic       exp_pe;
      logic       exp_se;
      logic [7:0] exp_pd;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int dv0, pe0, se0, qs;
      //          ps pen typ data   pb sb  dv pe se  P_DATA
      vecs[0] = '{8,  1, 0, 8'hA5, 0, 1,  1, 0, 0, 8'hA5};  // even parity ok
      vecs[1] = '{16, 1, 1, 8'h3C, 0, 1,  0, 1, 0, 8'hA5};  // odd parity wrong
      vecs[2] = '{8,  0, 0, 8'h81, 0, 0,  0, 0, 1, 8'hA5};  // stop bit low
      vecs[3] = '{32, 0, 0, 8'h55, 0, 1,  1, 0, 0, 8'h55};
      vecs[4] = '{16, 1, 0, 8'h5A, 0, 1,  1, 0, 0, 8'h5A};
      vecs[5] = '{8,  1, 1, 8'h01, 1, 0,  0, 1, 1, 8'h5A};  // both errors

      tick(3);
      chk("reset.P_DATA",     {24'd0, P_DATA}, 32'h0);
      chk("reset.data_valid", {31'd0, data_valid}, 32'h0);
      chk("reset.par_err",    {31'd0, par_err}, 32'h0);
      chk("reset.stp_err",    {31'd0, stp_err}, 32'h0);
      RST = 1'b1;
      tick(4);

      for (int i = 0; i < 6; i++)
         run_frame($sformatf("vec%0d", i), vecs[i].ps, vecs[i].pen, vecs[i].ptyp, vecs[i].data,
                   vecs[i].pbit, vecs[i].sbit, vecs[i].exp_dv, vecs[i].exp_pe,
                   vecs[i].exp_se, vecs[i].exp_pd);
      model_pd = 8'h5A;

      // Short low glitch must be rejected, then a normal frame received.
      Prescale = 6'd16; PAR_EN = 1'b0;
      dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
      RX_IN = 1'b0;
      tick(3);
      RX_IN = 1'b1;
      tick(40);
      chk("glitch.data_valid", dv_cnt - dv0, 0);
      chk("glitch.par_err",    pe_cnt - pe0, 0);
      chk("glitch.stp_err",    se_cnt - se0, 0);
      run_frame("after_glitch", 16, 0, 0, 8'h5A, 0, 1, 1, 0, 0, 8'h5A);

      // Back-to-back frames with a single stop bit.
      Prescale = 6'd32; PAR_EN = 1'b0;
      dv0 = dv_cnt; qs = dv_log.size();
      send_frame(8'h55, 0, 0, 1, 32);
      send_frame(8'h0F, 0, 0, 1, 32);
      tick(64);
      chk("b2b.count", dv_cnt - dv0, 2);
      if (dv_log.size() >= qs + 2) begin
         chk("b2b.first",  {24'd0, dv_log[qs]},     32'h55);
         chk("b2b.second", {24'd0, dv_log[qs + 1]}, 32'h0F);
      end else begin
         chk("b2b.log_size", dv_log.size() - qs, 2);
      end
      chk("b2b.P_DATA", {24'd0, P_DATA}, 32'h0F);

      // Reset in the middle of the data bits of an all-ones frame.
      Prescale = 6'd8; PAR_EN = 1'b0;
      fork
         send_frame(8'hFF, 0, 0, 1, 8);
         begin
            tick(8 + 3 * 8 + 3);
            RST = 1'b0;
            #1;
            chk("midrst.P_DATA",     {24'd0, P_DATA}, 32'h0);
            chk("midrst.data_valid", {31'd0, data_valid}, 32'h0);
            chk("midrst.par_err",    {31'd0, par_err}, 32'h0);
            chk("midrst.stp_err",    {31'd0, stp_err}, 32'h0);
            tick(2);
            RST = 1'b1;
         end
      join
      dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
      tick(16);
      chk("midrst.quiet", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);
      run_frame("after_rst", 8, 0, 0, 8'h12, 0, 1, 1, 0, 0, 8'h12);
      model_pd = 8'h12;

      // Random frames against the parity/stop model.
      for (int n = 0; n < 30; n++) begin
         int         ps;
         logic [7:0] d;
         logic       pen, ptyp, good_par, pbit, sbit, perr, serr, dv;
         ps       = 8 << $urandom_range(0, 2);
         d        = 8'($urandom);
         pen      = 1'($urandom);
         ptyp     = 1'($urandom);
         good_par = (^d) ^ ptyp;
         pbit     = good_par ^ ($urandom_range(0, 4) == 0);
         sbit     = !($urandom_range(0, 4) == 0);
         perr     = pen && (pbit != good_par);
         serr     = !sbit;
         dv       = !perr && !serr;
         if (dv) model_pd = d;
         run_frame($sformatf("rnd%0d", n), ps, pen, ptyp, d, pbit, sbit, dv, perr, serr, model_pd);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Serial-to-parallel UART receiver for the UART-to-APB bridge. It is the receive-side counterpart of the bridge's UART transmitter.
- Oversamples RX_IN, detects the start bit, majority-samples each bit and shifts data in LSB-first.
- Optionally checks parity and always checks the stop bit.
- Presents the byte with a one-cycle data_valid pulse to the bridge's command/frame decoder.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_W, 6, width of the Prescale input. Legal Prescale values are 8, 16 and 32.

Ports:
- CLK  input  1  oversampling clock (Prescale x baud rate).
- RST  input  1  asynchronous, active-low reset.
- RX_IN  input  1  serial line; idles high; asynchronous to CLK.
- PAR_EN  input  1  1 = parity bit present after the data bits.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- Prescale  input  PRESCALE_W  oversampling ratio.
- P_DATA  output  DATA_WIDTH  received byte; held until the next accepted frame.
- data_valid  output  1  one-cycle pulse: frame accepted with no errors.
- par_err  output  1  one-cycle pulse: parity mismatch.
- stp_err  output  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset (RST low, asynchronous):
  - All outputs go to 0.
  - State goes to IDLE; all counters clear; the synchronizer flops are set to 1.
- Input path: RX_IN passes through a 2-flop synchronizer; rx_s is the synchronized line. All further logic uses rx_s only.
- Counters:
  - edge_cnt runs 0..Prescale-1 and wraps to 0 at the end of each bit period.
  - bit_cnt counts completed data bits.
- Sampling: the bit value is the majority of rx_s captured at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1. It is resolved at edge_cnt = Prescale/2+2.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
  - IDLE: when rx_s = 0, go to START with edge_cnt = 0.
  - START: at resolve, if the sampled bit is 1 (glitch), go to IDLE with no outputs. At edge_cnt = Prescale-1, go to DATA.
  - DATA: at resolve, shift the bit into the shift register (LSB first). At edge_cnt = Prescale-1, increment bit_cnt. After DATA_WIDTH bits, go to PARITY if PAR_EN = 1, else STOP.
  - PARITY: at resolve, compare the bit against the XOR of the data bits, inverted when PAR_TYP = 1. Latch a mismatch internally. At edge_cnt = Prescale-1, go to STOP.
  - STOP: at resolve, go to DONE. The frame does not wait for the end of the stop bit, so back-to-back frames are not lost.
  - DONE: lasts one cycle.
    - If the stop bit was 0, pulse stp_err.
    - If the parity mismatch was latched, pulse par_err. par_err and stp_err may pulse in the same cycle.
    - If there are no errors, load P_DATA from the shift register and pulse data_valid.
    - On any error, P_DATA keeps its old value.
    - Then go to IDLE.
- IDLE re-arms only on rx_s = 0. The remainder of the stop bit is high, so no false start occurs.
- Latency: data_valid asserts 1 cycle after the stop-bit resolve point, i.e. about 2 + (DATA_WIDTH+1+PAR_EN)*Prescale + Prescale/2 + 3 cycles after the RX_IN falling edge.
- Configuration: PAR_EN, PAR_TYP and Prescale are sampled continuously. They must only change in IDLE; a mid-frame change is undefined.
- Illegal Prescale values: behaviour is undefined, but the FSM must still return to IDLE (no lock-up).
- Reset mid-frame: immediately returns to IDLE with outputs 0. The first start bit after reset release is received correctly.

Decomposition:
- Shared package uart_rx_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP, DONE);
  - sample-offset constants (-1, 0, +1, resolve +2);
  - parity-type encodings EVEN = 0, ODD = 1.
- One natural sub-module, uart_rx_sampler: 3-sample majority voter plus edge_cnt, with output bit_val and resolve strobe.
- The FSM, shift register and parity checker stay in uart_rx_frame.

Test Plan:
- Prescale=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity 0 -> P_DATA=0xA5, exactly one data_valid pulse, par_err=0, stp_err=0.
- Prescale=16, PAR_EN=1, PAR_TYP=1, frame 0x3C with wrong parity bit 0 -> par_err pulses once, data_valid stays 0, P_DATA unchanged.
- Prescale=8, PAR_EN=0, frame 0x81 with stop bit driven 0 -> stp_err pulses, no data_valid.
- Prescale=16, RX_IN low for 3 cycles then high -> no outputs; FSM back in IDLE; the next valid frame 0x5A is received correctly.
- Prescale=32, PAR_EN=0, back-to-back frames 0x55 then 0x0F with a single stop bit -> two data_valid pulses, P_DATA=0x55 then 0x0F.
- Prescale=8, RST asserted mid-DATA of frame 0xFF -> outputs go to 0 immediately; after release, frame 0x12 gives P_DATA=0x12 and data_valid.
